// File: rtl/obstacle_collision_checker_pkg.sv
// Shared game constants and types: state encoding, screen size, cursor and HP defaults.
package obstacle_collision_checker_pkg;

    localparam int PIX_W             = 12;
    localparam int HP_W              = 7;
    localparam int SCREEN_W          = 1024;
    localparam int SCREEN_H          = 768;
    localparam int DEF_CURSOR_W      = 12;
    localparam int DEF_CURSOR_H      = 20;
    localparam int DEF_MAX_HP        = 100;
    localparam int DEF_DAMAGE        = 10;
    localparam int DEF_INVULN_FRAMES = 60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } game_state_t;

    // Saturating HP subtraction: a hit never wraps below zero.
    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                     input logic [HP_W-1:0] dmg);
        return (hp <= dmg) ? '0 : hp - dmg;
    endfunction

endpackage

// File: rtl/obstacle_collision_checker_if.sv
// Pixel/cursor/game-control inputs and HUD/status outputs of the collision checker.
interface obstacle_collision_checker_if;
    import obstacle_collision_checker_pkg::*;

    logic [PIX_W-1:0] obstacle_x;
    logic [PIX_W-1:0] obstacle_y;
    logic [PIX_W-1:0] mouse_xpos;
    logic [PIX_W-1:0] mouse_ypos;
    logic             frame_start;
    logic             game_start;
    logic             game_active;
    logic [HP_W-1:0]  hp;
    logic             hit;
    logic             invulnerable;
    logic             game_over;

    modport master (
        output obstacle_x, obstacle_y, mouse_xpos, mouse_ypos,
               frame_start, game_start, game_active,
        input  hp, hit, invulnerable, game_over
    );

    modport slave (
        input  obstacle_x, obstacle_y, mouse_xpos, mouse_ypos,
               frame_start, game_start, game_active,
        output hp, hit, invulnerable, game_over
    );

endinterface

// File: rtl/obstacle_collision_checker_cursor_box_match.sv
// Registered pixel-in-box test: one cycle after a pixel arrives, match_q says whether it
// fell inside the box anchored at (box_x, box_y). Coordinate (0,0) means "no pixel".
module cursor_box_match
    import obstacle_collision_checker_pkg::*;
#(
    parameter int BOX_W = DEF_CURSOR_W,
    parameter int BOX_H = DEF_CURSOR_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] px,
    input  logic [PIX_W-1:0] py,
    input  logic [PIX_W-1:0] box_x,
    input  logic [PIX_W-1:0] box_y,
    output logic             match_q
);

    // Far edges carry one extra bit so a box near 4095 does not wrap to small values.
    localparam logic [PIX_W:0] W_M1 = (PIX_W+1)'(BOX_W - 1);
    localparam logic [PIX_W:0] H_M1 = (PIX_W+1)'(BOX_H - 1);

    logic [PIX_W:0] x_hi;
    logic [PIX_W:0] y_hi;
    logic           match_d;

    // Inclusive box compare on all four edges.
    always_comb begin
        x_hi    = {1'b0, box_x} + W_M1;
        y_hi    = {1'b0, box_y} + H_M1;
        match_d = ((px != '0) || (py != '0)) &&
                  (px >= box_x) && ({1'b0, px} <= x_hi) &&
                  (py >= box_y) && ({1'b0, py} <= y_hi);
    end

    // One-cycle result register.
    always_ff @(posedge clk) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match_d;
    end

endmodule

// File: rtl/obstacle_collision_checker.sv
// Obstacle-vs-cursor collision checker: at most one hit per frame, HP bookkeeping,
// post-hit invulnerability window and game-over flag for the HUD and game FSM.
module obstacle_collision_checker
    import obstacle_collision_checker_pkg::*;
#(
    parameter int MAX_HP        = DEF_MAX_HP,
    parameter int DAMAGE        = DEF_DAMAGE,
    parameter int CURSOR_W      = DEF_CURSOR_W,
    parameter int CURSOR_H      = DEF_CURSOR_H,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    obstacle_collision_checker_if.slave  bus
);

    localparam int              CNT_W    = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
    localparam logic [HP_W-1:0] HP_INIT  = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] HP_DMG   = HP_W'(DAMAGE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES - 1);

    logic [PIX_W-1:0] mx_q, mx_d, my_q, my_d;
    logic             match_q;
    logic             flag_q, flag_d;
    game_state_t      state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             inv_q, inv_d;
    logic             go_q, go_d;

    cursor_box_match #(
        .BOX_W (CURSOR_W),
        .BOX_H (CURSOR_H)
    ) u_match (
        .clk     (pclk),
        .rst_n   (rst_n),
        .px      (bus.obstacle_x),
        .py      (bus.obstacle_y),
        .box_x   (mx_q),
        .box_y   (my_q),
        .match_q (match_q)
    );

    // Cursor box is frozen for the whole frame, sampled on frame_start.
    always_comb begin
        mx_d = mx_q;
        my_d = my_q;
        if (bus.frame_start) begin
            mx_d = bus.mouse_xpos;
            my_d = bus.mouse_ypos;
        end
    end

    // Sticky per-frame hit flag. A match on the boundary cycle belongs to the new frame,
    // so the clear comes first and the set overrides it; game_start wipes everything.
    always_comb begin
        flag_d = flag_q;
        if (bus.frame_start)
            flag_d = 1'b0;
        if (match_q && (state_q == ST_ACTIVE) && bus.game_active)
            flag_d = 1'b1;
        if (bus.game_start)
            flag_d = 1'b0;
    end

    // Game FSM: damage is decided once per frame from the previous frame's flag.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        if (bus.game_start) begin
            state_d = ST_ACTIVE;
            hp_d    = HP_INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (bus.frame_start && flag_q && bus.game_active) begin
                        hp_d  = hp_after_hit(hp_q, HP_DMG);
                        hit_d = 1'b1;
                        if (hp_d == '0) begin
                            state_d = ST_DEAD;
                        end else begin
                            state_d = ST_INVULN;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                ST_INVULN: begin
                    if (bus.frame_start) begin
                        if (cnt_q == '0) state_d = ST_ACTIVE;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                end
                ST_DEAD:  hp_d = '0;
                default:  ;
            endcase
        end
        // invulnerable tracks the state being entered; game_over lags the DEAD state by
        // one cycle so the lethal hit pulse and game_over never rise together.
        inv_d = (state_d == ST_INVULN);
        go_d  = (state_q == ST_DEAD);
    end

    // All state and output registers, synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            mx_q    <= '0;
            my_q    <= '0;
            flag_q  <= 1'b0;
            state_q <= ST_IDLE;
            hp_q    <= HP_INIT;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            mx_q    <= mx_d;
            my_q    <= my_d;
            flag_q  <= flag_d;
            state_q <= state_d;
            hp_q    <= hp_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            inv_q   <= inv_d;
            go_q    <= go_d;
        end
    end

    assign bus.hp           = hp_q;
    assign bus.hit          = hit_q;
    assign bus.invulnerable = inv_q;
    assign bus.game_over    = go_q;

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Bench for obstacle_collision_checker: a default instance and a MAX_HP=5 instance share
// one stimulus stream; expectations go into a scoreboard queue and are popped after the edge.
module tb_obstacle_collision_checker;

    logic        pclk;
    logic        rst_n;
    logic [11:0] obs_x, obs_y, mouse_x, mouse_y;
    logic        fs, gs, ga;

    int checks = 0;
    int errors = 0;

    obstacle_collision_checker_if bus_a ();
    obstacle_collision_checker_if bus_b ();

    assign bus_a.obstacle_x  = obs_x;
    assign bus_a.obstacle_y  = obs_y;
    assign bus_a.mouse_xpos  = mouse_x;
    assign bus_a.mouse_ypos  = mouse_y;
    assign bus_a.frame_start = fs;
    assign bus_a.game_start  = gs;
    assign bus_a.game_active = ga;
    assign bus_b.obstacle_x  = obs_x;
    assign bus_b.obstacle_y  = obs_y;
    assign bus_b.mouse_xpos  = mouse_x;
    assign bus_b.mouse_ypos  = mouse_y;
    assign bus_b.frame_start = fs;
    assign bus_b.game_start  = gs;
    assign bus_b.game_active = ga;

    obstacle_collision_checker dut_a (.pclk(pclk), .rst_n(rst_n), .bus(bus_a));
    obstacle_collision_checker #(.MAX_HP(5)) dut_b (.pclk(pclk), .rst_n(rst_n), .bus(bus_b));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        string      name;
        bit         sel_b;
        logic       hit;
        logic [6:0] hp;
        logic       inv;
        logic       go;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string name;
        int    mx, my, px, py, n;
        bit    ga;
        bit    hit;
        int    hp;
    } vec_t;

    vec_t vt[11];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        step();
        fs = 1'b0;
    endtask

    task automatic start_game();
        gs = 1'b1;
        step();
        gs = 1'b0;
    endtask

    task automatic latch_mouse(input int x, input int y);
        mouse_x = 12'(x);
        mouse_y = 12'(y);
        pulse_fs();
    endtask

    // n pixel cycles, then enough idle cycles for the flag to settle before the boundary.
    task automatic drive_pixels(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) begin
            obs_x = 12'(x);
            obs_y = 12'(y);
            step();
        end
        obs_x = '0;
        obs_y = '0;
        repeat (3) step();
    endtask

    task automatic expect_out(input string n, input bit b, input logic h,
                              input int hp, input logic inv, input logic go);
        exp_t e;
        e.name = n; e.sel_b = b; e.hit = h; e.hp = 7'(hp); e.inv = inv; e.go = go;
        sb.push_back(e);
    endtask

    task automatic cmp(input string n, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", n, f, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (e.sel_b) begin
            cmp(e.name, "hit", int'(bus_b.hit), int'(e.hit));
            cmp(e.name, "hp", int'(bus_b.hp), int'(e.hp));
            cmp(e.name, "invulnerable", int'(bus_b.invulnerable), int'(e.inv));
            cmp(e.name, "game_over", int'(bus_b.game_over), int'(e.go));
        end else begin
            cmp(e.name, "hit", int'(bus_a.hit), int'(e.hit));
            cmp(e.name, "hp", int'(bus_a.hp), int'(e.hp));
            cmp(e.name, "invulnerable", int'(bus_a.invulnerable), int'(e.inv));
            cmp(e.name, "game_over", int'(bus_a.game_over), int'(e.go));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{"inside",      500, 400, 505, 410, 1, 1'b1, 1'b1, 90};
        vt[1]  = '{"x_out_by1",   500, 400, 512, 400, 1, 1'b1, 1'b0, 100};
        vt[2]  = '{"far_corner",  500, 400, 511, 419, 1, 1'b1, 1'b1, 90};
        vt[3]  = '{"top_left",    500, 400, 500, 400, 1, 1'b1, 1'b1, 90};
        vt[4]  = '{"left_out",    500, 400, 499, 400, 1, 1'b1, 1'b0, 100};
        vt[5]  = '{"bottom_out",  500, 400, 500, 420, 1, 1'b1, 1'b0, 100};
        vt[6]  = '{"top_out",     500, 400, 505, 399, 1, 1'b1, 1'b0, 100};
        vt[7]  = '{"null_pixel",  0,   0,   0,   0,   5, 1'b1, 1'b0, 100};
        vt[8]  = '{"origin_hit",  0,   0,   0,   1,   1, 1'b1, 1'b1, 90};
        vt[9]  = '{"no_wrap_hit", 4090, 4090, 4095, 4095, 1, 1'b1, 1'b1, 90};
        vt[10] = '{"no_wrap_low", 4090, 4090, 5,   5,   1, 1'b1, 1'b0, 100};

        rst_n = 1'b0; obs_x = '0; obs_y = '0; mouse_x = '0; mouse_y = '0;
        fs = 1'b0; gs = 1'b0; ga = 1'b1;
        step();
        step();
        expect_out("reset_a", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        expect_out("reset_b", 1'b1, 1'b0, 5, 1'b0, 1'b0);
        check_out();
        check_out();
        rst_n = 1'b1;
        step();

        // Single-frame geometry vectors, each from a fresh game.
        foreach (vt[i]) begin
            start_game();
            latch_mouse(vt[i].mx, vt[i].my);
            ga = vt[i].ga;
            drive_pixels(vt[i].n, vt[i].px, vt[i].py);
            expect_out(vt[i].name, 1'b0, vt[i].hit, vt[i].hp, vt[i].hit, 1'b0);
            pulse_fs();
            check_out();
            expect_out({vt[i].name, "_next"}, 1'b0, 1'b0, vt[i].hp, vt[i].hit, 1'b0);
            step();
            check_out();
            ga = 1'b1;
        end

        // game_active low: overlaps for 3 frames never count.
        start_game();
        latch_mouse(500, 400);
        ga = 1'b0;
        for (int f = 0; f < 3; f++) begin
            drive_pixels(4, 505, 410);
            expect_out("inactive", 1'b0, 1'b0, 100, 1'b0, 1'b0);
            pulse_fs();
            check_out();
        end
        ga = 1'b1;
        expect_out("inactive_resume", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        pulse_fs();
        check_out();

        // A match landing on the boundary cycle is charged to the following frame.
        obs_x = 12'd505; obs_y = 12'd410;
        step();
        obs_x = '0; obs_y = '0;
        expect_out("boundary_match_now", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        pulse_fs();
        check_out();
        repeat (3) step();
        expect_out("boundary_match_next", 1'b0, 1'b1, 90, 1'b1, 1'b0);
        pulse_fs();
        check_out();

        // 50 pixels in one frame -> one hit; then the full immunity window.
        start_game();
        latch_mouse(500, 400);
        drive_pixels(50, 505, 410);
        expect_out("multi_pixel", 1'b0, 1'b1, 90, 1'b1, 1'b0);
        pulse_fs();
        check_out();
        for (int k = 1; k <= 60; k++) begin
            drive_pixels(2, 505, 410);
            expect_out($sformatf("invuln_f%0d", k), 1'b0, 1'b0, 90, (k < 60), 1'b0);
            pulse_fs();
            check_out();
        end
        drive_pixels(2, 505, 410);
        expect_out("after_window", 1'b0, 1'b1, 80, 1'b1, 1'b0);
        pulse_fs();
        check_out();

        // game_start beats a damaging frame_start on the same cycle.
        start_game();
        latch_mouse(500, 400);
        drive_pixels(3, 505, 410);
        gs = 1'b1;
        expect_out("start_priority", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        pulse_fs();
        gs = 1'b0;
        check_out();
        repeat (3) step();
        expect_out("start_flag_cleared", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        pulse_fs();
        check_out();
        drive_pixels(1, 505, 410);
        expect_out("start_is_active", 1'b0, 1'b1, 90, 1'b1, 1'b0);
        pulse_fs();
        check_out();

        // Reset while invulnerable, then IDLE ignores overlaps.
        rst_n = 1'b0;
        expect_out("reset_invuln_a", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        expect_out("reset_invuln_b", 1'b1, 1'b0, 5, 1'b0, 1'b0);
        step();
        check_out();
        check_out();
        rst_n = 1'b1;
        latch_mouse(500, 400);
        drive_pixels(3, 505, 410);
        expect_out("idle_ignores", 1'b0, 1'b0, 100, 1'b0, 1'b0);
        pulse_fs();
        check_out();

        // Lethal hit on the MAX_HP=5 instance.
        start_game();
        latch_mouse(500, 400);
        drive_pixels(2, 505, 410);
        expect_out("lethal_b", 1'b1, 1'b1, 0, 1'b0, 1'b0);
        expect_out("lethal_a", 1'b0, 1'b1, 90, 1'b1, 1'b0);
        pulse_fs();
        check_out();
        check_out();
        expect_out("dead_b", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        step();
        check_out();
        drive_pixels(2, 505, 410);
        expect_out("dead_hold_b", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        pulse_fs();
        check_out();
        expect_out("revive_b", 1'b1, 1'b0, 5, 1'b0, 1'b1);
        start_game();
        check_out();
        expect_out("revive_next_b", 1'b1, 1'b0, 5, 1'b0, 1'b0);
        step();
        check_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_collision_checker.md
Name: obstacle_collision_checker

Overview:
- Sits directly downstream of the obstacle drawing modules (pillars, etc.). Consumes their per-pixel obstacle_x/obstacle_y reports.
- Tests each reported obstacle pixel against the mouse cursor box and registers at most one hit per frame.
- Manages player HP with a post-hit invulnerability window and flags game over.
- Feeds the HUD (hp, invulnerable) and the game-control FSM (hit, game_over).

Parameters:
- MAX_HP, 100, HP loaded on reset and on game_start; must fit in 7 bits.
- DAMAGE, 10, HP removed per registered hit.
- CURSOR_W, 12, cursor hit-box width in pixels.
- CURSOR_H, 20, cursor hit-box height in pixels.
- INVULN_FRAMES, 60, frames of immunity after a hit.

Ports:
- pclk  in  1  pixel clock; the block's only clock.
- rst_n  in  1  synchronous active-low reset.
- obstacle_x  in  12  obstacle pixel hcount; 0 means no pixel this cycle.
- obstacle_y  in  12  obstacle pixel vcount; 0 means no pixel this cycle.
- mouse_xpos  in  12  cursor top-left x; sampled at frame_start.
- mouse_ypos  in  12  cursor top-left y; sampled at frame_start.
- frame_start  in  1  one-cycle pulse at the start of each frame (vcount=0, hcount=0).
- game_start  in  1  pulse; reloads HP and arms the checker.
- game_active  in  1  level; high while an obstacle is running.
- hp  out  7  current HP.
- hit  out  1  one-cycle pulse when damage is applied.
- invulnerable  out  1  high during the immunity window.
- game_over  out  1  level; high in state DEAD.

Behaviour:
- Reset (rst_n=0 at a pclk edge):
  - state=IDLE, hp=MAX_HP, hit=0, invulnerable=0, game_over=0.
  - Frame flag cleared, invulnerability counter cleared, latched cursor cleared to 0.
- Cursor latch: at each frame_start, mx<=mouse_xpos and my<=mouse_ypos. The box stays stable for the whole frame.
- Pixel test (registered, 1-cycle latency):
  - match = (obstacle_x!=0 || obstacle_y!=0) && mx<=obstacle_x<=mx+CURSOR_W-1 && my<=obstacle_y<=my+CURSOR_H-1.
  - Box edges are inclusive. Compute edges in 13 bits so mx+CURSOR_W does not wrap at 4095.
  - match_q feeds a sticky frame flag, which is set only while state=ACTIVE and game_active=1.
- Frame boundary, on a frame_start cycle:
  - The decision uses the flag value from before this edge; then the flag clears.
  - A match_q arriving on that same cycle sets the flag for the new frame.
- States:
  - IDLE:
    - game_start -> ACTIVE with hp=MAX_HP.
    - Flag is ignored.
  - ACTIVE:
    - On frame_start with flag=1, apply damage: hp = (hp<=DAMAGE) ? 0 : hp-DAMAGE, and pulse hit for 1 cycle.
    - If the new hp==0 -> DEAD; otherwise -> INVULN with counter=INVULN_FRAMES-1.
  - INVULN:
    - invulnerable=1; flag does not set.
    - Each frame_start: if counter==0 -> ACTIVE, else counter-1.
    - Window length is exactly INVULN_FRAMES frame_start pulses.
  - DEAD:
    - game_over=1; hp holds 0.
    - game_start -> ACTIVE with hp=MAX_HP and game_over clears on the next cycle.
- game_start in ACTIVE or INVULN: reload hp=MAX_HP, clear the flag and counter, go to ACTIVE.
- game_start has priority over a simultaneous frame_start damage decision.
- game_active=0 while ACTIVE/INVULN: flag cannot set. The invulnerability counter still runs. HP is held.
- At most one hit per frame, no matter how many pixels overlap.
- hit and game_over are never both asserting a new event on the same cycle except on the lethal hit, where hit=1 and game_over rises 1 cycle later (registered state).

Decomposition:
- Shared game package holds:
  - State encodings IDLE/ACTIVE/INVULN/DEAD (2 bits).
  - Screen constants (1024x768).
  - Default cursor dimensions and HP constants, which are shared with the HUD and the mouse drawing module.
- One sub-module: cursor_box_match. Purely the registered pixel-in-box compare (12-bit in, 1-bit out, 1-cycle latency). It is reused by future pickup/bonus checkers.

Test Plan:
- Reset then game_start; mouse=(500,400); inject obstacle pixel (505,410) mid-frame -> next frame_start: hit pulse, hp 100->90, invulnerable=1.
- Pixel at (512,400) with mouse=(500,400) (x=mx+CURSOR_W, outside by one) -> no hit. Pixel at (511,419) -> hit, confirming inclusive edges.
- 50 overlapping pixels in one frame -> exactly one hit, hp=90. Same overlap during the next 60 frames -> hp stays 90. Frame 61 overlap -> hp=80.
- hp=5 via MAX_HP=5 override, DAMAGE=10 -> hp saturates to 0, hit=1, game_over=1 one cycle later. Further overlaps leave hp at 0.
- game_start asserted on the same cycle as a damaging frame_start -> hp=MAX_HP, no hit, state ACTIVE. rst_n=0 mid-INVULN -> all outputs at reset values on the next edge.
- game_active=0 with overlapping pixels for 3 frames -> no hit. obstacle_x=obstacle_y=0 with cursor at (0,0) -> no hit.
